// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single RAM port among the instruction and data caches of CPUS cores.
// Data traffic outranks instruction fetches. A starvation counter forces an
// instruction grant after STARVE_LIMIT data grants while a fetch is pending.
// Ownership rotates round-robin among the cores. A data grant moves BURST words.
// An instruction grant moves one word. Every grant is followed by one IDLE cycle.

module ram_port_arbiter #(
  parameter int CPUS         = 2,
  parameter int BURST        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS*32-1:0]        iaddr,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS*32-1:0]        daddr,
  input  logic [CPUS*32-1:0]        dstore,
  input  logic [1:0]                ramstate,
  input  logic [31:0]               ramload,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS*32-1:0]        iload,
  output logic [CPUS*32-1:0]        dload,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  output logic                      grant_valid,
  output logic [$clog2(CPUS)-1:0]   grant_owner
);

  localparam int IW = $clog2(CPUS);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic [IW-1:0] rr_ptr_q,     rr_ptr_d;
  logic [BW-1:0] beat_cnt_q,   beat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [IW-1:0] owner_q,      owner_d;
  logic          op_write_q,   op_write_d;

  logic [CPUS-1:0] d_req;
  logic            any_d_req;
  logic            any_i_req;
  logic            force_instr;
  logic [IW-1:0]   d_pick;
  logic [IW-1:0]   i_pick;
  logic            ram_access;
  logic            own_d_req;
  logic            own_i_req;
  logic [IW+4:0]   own_base;
  logic [31:0]     own_iaddr;
  logic [31:0]     own_daddr;
  logic [31:0]     own_dstore;
  logic [IW-1:0]   owner_next;

  // Scan the requests starting at ptr. Return the first set requester.
  // The scan runs from the far end back toward ptr, so the requester
  // closest to ptr is the last one written and therefore wins.
  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] sel;
    int            idx;
    sel = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      if (req[IW'(idx)]) sel = IW'(idx);
    end
    return sel;
  endfunction

  // Advance a CPU index by one, wrapping from CPUS-1 back to 0.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    if (int'(p) == CPUS - 1) return '0;
    return p + IW'(1);
  endfunction

  assign d_req       = dREN | dWEN;
  assign any_d_req   = |d_req;
  assign any_i_req   = |iREN;
  assign force_instr = (starve_cnt_q == STARVE_MAX) && any_i_req;
  assign d_pick      = rr_pick(d_req, rr_ptr_q);
  assign i_pick      = rr_pick(iREN, rr_ptr_q);
  assign ram_access  = (ramstate_t'(ramstate) == ACCESS);

  assign own_d_req   = d_req[owner_q];
  assign own_i_req   = iREN[owner_q];
  assign own_base    = {owner_q, 5'd0};
  assign own_iaddr   = iaddr[own_base +: 32];
  assign own_daddr   = daddr[own_base +: 32];
  assign own_dstore  = dstore[own_base +: 32];
  assign owner_next  = wrap_inc(owner_q);

  // Next-state logic: arbitration in IDLE, and beat counting or abort while a grant is held.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    op_write_d   = op_write_q;

    case (state_q)
      IDLE: begin
        if (any_d_req && !force_instr) begin
          state_d    = DGRANT;
          owner_d    = d_pick;
          op_write_d = dWEN[d_pick];
          beat_cnt_d = '0;
        end else if (any_i_req) begin
          state_d    = IGRANT;
          owner_d    = i_pick;
          op_write_d = 1'b0;
          beat_cnt_d = '0;
        end
      end

      DGRANT: begin
        if (!own_d_req) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (ram_access) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = owner_next;
            if (any_i_req) begin
              if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + SW'(1);
            end else begin
              starve_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end

      IGRANT: begin
        if (!own_i_req) begin
          state_d = IDLE;
        end else if (ram_access) begin
          state_d      = IDLE;
          rr_ptr_d     = owner_next;
          starve_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers. nRST returns everything to IDLE immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_q      <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      op_write_q   <= op_write_d;
    end
  end

  // Route the owner's request to the RAM, and route the RAM data back to the owner only.
  // A wait is released only on an ACCESS cycle while the request is still held.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    grant_valid = 1'b0;
    grant_owner = '0;

    case (state_q)
      DGRANT: begin
        grant_valid = 1'b1;
        grant_owner = owner_q;
        ramaddr     = own_daddr;
        if (op_write_q) begin
          ramWEN   = 1'b1;
          ramstore = own_dstore;
        end else begin
          ramREN                 = 1'b1;
          dload[own_base +: 32]  = ramload;
        end
        if (ram_access && own_d_req) dwait[owner_q] = 1'b0;
      end

      IGRANT: begin
        grant_valid            = 1'b1;
        grant_owner            = owner_q;
        ramREN                 = 1'b1;
        ramaddr                = own_iaddr;
        iload[own_base +: 32]  = ramload;
        if (ram_access && own_i_req) iwait[owner_q] = 1'b0;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a transaction-level reference model of the
// arbitration rules.

module tb_ram_port_arbiter;

  localparam int CPUS         = 2;
  localparam int BURST        = 2;
  localparam int STARVE_LIMIT = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic        grant_valid;
  logic        grant_owner;

  int compared   = 0;
  int mismatched = 0;

  // reference model: the current grant as a transaction record plus the two counters
  int m_active, m_data, m_owner, m_write, m_beats, m_rr, m_starve;

  // outputs captured at the most recent check point
  logic [1:0]  obs_iwait, obs_dwait;
  logic        obs_ren, obs_wen, obs_gv, obs_owner;
  logic [31:0] obs_addr;
  logic [63:0] obs_iload;

  bit freeze_data = 1'b0;

  ram_port_arbiter #(.CPUS(CPUS), .BURST(BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .grant_valid(grant_valid), .grant_owner(grant_owner)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_active = 0; m_data = 0; m_owner = 0; m_write = 0;
    m_beats  = 0; m_rr   = 0; m_starve = 0;
  endtask

  function automatic int pickFirst(input logic [1:0] req);
    int r;
    int c;
    r = 32'(req);
    for (int k = 0; k < CPUS; k++) begin
      c = (m_rr + k) % CPUS;
      if (((r >> c) % 2) == 1) return c;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input logic [1:0] i_r, input logic [1:0] d_r,
                               input logic [1:0] d_w, input logic [1:0] rs);
    iREN     = i_r;
    dREN     = d_r;
    dWEN     = d_w;
    ramstate = rs;
    if (!freeze_data) begin
      iaddr  = {$urandom, $urandom};
      daddr  = {$urandom, $urandom};
      dstore = {$urandom, $urandom};
    end
    ramload = $urandom;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0]  e_iwait, e_dwait;
    logic [63:0] e_iload, e_dload;
    logic        e_ren, e_wen, e_gv, e_owner;
    logic [31:0] e_addr, e_store;
    int          own_req;
    e_iwait = 2'b11; e_dwait = 2'b11; e_iload = '0; e_dload = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_gv = 1'b0; e_owner = 1'b0;
    e_addr = '0; e_store = '0;
    if (m_active != 0) begin
      e_gv    = 1'b1;
      e_owner = (m_owner == 1);
      if (m_data != 0) begin
        e_addr  = daddr[m_owner*32 +: 32];
        own_req = 32'(dREN[m_owner] | dWEN[m_owner]);
        if (m_write != 0) begin
          e_wen   = 1'b1;
          e_store = dstore[m_owner*32 +: 32];
        end else begin
          e_ren                    = 1'b1;
          e_dload[m_owner*32 +: 32] = ramload;
        end
        if (ramstate == RS_ACCESS && own_req != 0) e_dwait[m_owner] = 1'b0;
      end else begin
        e_ren                    = 1'b1;
        e_addr                   = iaddr[m_owner*32 +: 32];
        e_iload[m_owner*32 +: 32] = ramload;
        if (ramstate == RS_ACCESS && iREN[m_owner]) e_iwait[m_owner] = 1'b0;
      end
    end
    cmp({tag, ".iwait"},       64'(iwait),       64'(e_iwait));
    cmp({tag, ".dwait"},       64'(dwait),       64'(e_dwait));
    cmp({tag, ".iload"},       iload,            e_iload);
    cmp({tag, ".dload"},       dload,            e_dload);
    cmp({tag, ".ramREN"},      64'(ramREN),      64'(e_ren));
    cmp({tag, ".ramWEN"},      64'(ramWEN),      64'(e_wen));
    cmp({tag, ".ramaddr"},     64'(ramaddr),     64'(e_addr));
    cmp({tag, ".ramstore"},    64'(ramstore),    64'(e_store));
    cmp({tag, ".grant_valid"}, 64'(grant_valid), 64'(e_gv));
    cmp({tag, ".grant_owner"}, 64'(grant_owner), 64'(e_owner));
    obs_iwait = iwait; obs_dwait = dwait; obs_ren = ramREN; obs_wen = ramWEN;
    obs_gv = grant_valid; obs_owner = grant_owner; obs_addr = ramaddr; obs_iload = iload;
  endtask

  // Advance the model by one clock edge, using the inputs held during the cycle.
  task automatic modelAdvance();
    logic [1:0] dreq;
    dreq = dREN | dWEN;
    if (!nRST) begin
      modelReset();
    end else if (m_active == 0) begin
      if (dreq != 0 && !(m_starve == STARVE_LIMIT && iREN != 0)) begin
        m_owner  = pickFirst(dreq);
        m_active = 1; m_data = 1; m_beats = 0;
        m_write  = 32'(dWEN[m_owner]);
      end else if (iREN != 0) begin
        m_owner  = pickFirst(iREN);
        m_active = 1; m_data = 0; m_beats = 0; m_write = 0;
      end
    end else if (m_data != 0) begin
      if (!(dREN[m_owner] | dWEN[m_owner])) begin
        m_active = 0;
      end else if (ramstate == RS_ACCESS) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_active = 0;
          m_rr     = (m_owner + 1) % CPUS;
          if (iREN != 0) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
          else m_starve = 0;
        end
      end
    end else begin
      if (!iREN[m_owner]) begin
        m_active = 0;
      end else if (ramstate == RS_ACCESS) begin
        m_active = 0;
        m_rr     = (m_owner + 1) % CPUS;
        m_starve = 0;
      end
    end
  endtask

  task automatic runCycle(input string tag);
    @(negedge CLK);
    checkOutput(tag);
    modelAdvance();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int  c0, c1, dgrants;
    bit  found;
    logic prev_gv;
    logic [1:0] rs;
    logic [31:0] iload_exp;

    modelReset();
    nRST = 1'b0;
    applyStimulus(2'b11, 2'b11, 2'b11, RS_ACCESS);

    // reset with every request raised
    runCycle("rst");
    runCycle("rst");
    cmp("rst_iwait", 64'(obs_iwait), 64'(2'b11));
    cmp("rst_dwait", 64'(obs_dwait), 64'(2'b11));
    cmp("rst_ramREN", 64'(obs_ren), 64'(0));
    cmp("rst_ramWEN", 64'(obs_wen), 64'(0));
    cmp("rst_grant_valid", 64'(obs_gv), 64'(0));
    nRST = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("idle");

    // two data readers share the port, two beats each
    c0 = 0; c1 = 0;
    for (int n = 0; n < 6; n++) begin
      applyStimulus(2'b00, 2'b11, 2'b00, RS_ACCESS);
      runCycle("t2");
      if (obs_dwait[0] == 1'b0) c0++;
      if (obs_dwait[1] == 1'b0) c1++;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t2");
    cmp("t2_cpu0_beats", 64'(c0), 64'(2));
    cmp("t2_cpu1_beats", 64'(c1), 64'(2));
    cmp("t2_rr_ptr", 64'(dut.rr_ptr_q), 64'(0));

    // a pending fetch is forced through after STARVE_LIMIT data grants
    dgrants = 0; found = 1'b0; prev_gv = 1'b0; iload_exp = '0;
    for (int n = 0; n < 40 && !found; n++) begin
      applyStimulus(2'b10, 2'b00, 2'b01, RS_ACCESS);
      iload_exp = ramload;
      runCycle("t3");
      if (obs_gv && obs_wen && !prev_gv) dgrants++;
      if (obs_gv && obs_ren && obs_owner) found = 1'b1;
      prev_gv = obs_gv;
    end
    cmp("t3_found_igrant", 64'(found), 64'(1));
    cmp("t3_data_grants", 64'(dgrants), 64'(STARVE_LIMIT));
    cmp("t3_iwait", 64'(obs_iwait), 64'(2'b01));
    cmp("t3_iload1", 64'(obs_iload[63:32]), 64'(iload_exp));
    cmp("t3_starve_cnt", 64'(dut.starve_cnt_q), 64'(0));
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t3");

    // a write held through three BUSY cycles
    applyStimulus(2'b00, 2'b00, 2'b10, RS_BUSY);
    freeze_data = 1'b1;
    runCycle("t4");
    for (int n = 0; n < 3; n++) begin
      ramload = $urandom;
      runCycle("t4");
      cmp("t4_busy_wen", 64'(obs_wen), 64'(1));
      cmp("t4_busy_addr", 64'(obs_addr), 64'(daddr[63:32]));
      cmp("t4_busy_dwait", 64'(obs_dwait), 64'(2'b11));
    end
    ramstate = RS_ACCESS;
    runCycle("t4");
    cmp("t4_access_wen", 64'(obs_wen), 64'(1));
    cmp("t4_access_addr", 64'(obs_addr), 64'(daddr[63:32]));
    cmp("t4_access_dwait", 64'(obs_dwait), 64'(2'b01));
    runCycle("t4");
    freeze_data = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t4");

    // the data owner drops its request mid-burst, and the waiting fetch wins
    applyStimulus(2'b10, 2'b01, 2'b00, RS_ACCESS);
    runCycle("t5");
    applyStimulus(2'b10, 2'b01, 2'b00, RS_ACCESS);
    runCycle("t5");
    applyStimulus(2'b10, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t5");
    cmp("t5_abort_dwait", 64'(obs_dwait), 64'(2'b11));
    cmp("t5_rr_ptr", 64'(dut.rr_ptr_q), 64'(0));
    cmp("t5_starve_cnt", 64'(dut.starve_cnt_q), 64'(0));
    applyStimulus(2'b10, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t5");
    applyStimulus(2'b10, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t5");
    cmp("t5_igrant_owner", 64'(obs_owner), 64'(1));
    cmp("t5_igrant_ren", 64'(obs_ren), 64'(1));
    cmp("t5_igrant_iwait", 64'(obs_iwait), 64'(2'b01));
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t5");

    // reset pulsed during the second beat of a write
    applyStimulus(2'b00, 2'b00, 2'b01, RS_ACCESS);
    runCycle("t6");
    applyStimulus(2'b00, 2'b00, 2'b01, RS_ACCESS);
    runCycle("t6");
    applyStimulus(2'b00, 2'b00, 2'b01, RS_ACCESS);
    #2;
    cmp("t6_pre_gv", 64'(grant_valid), 64'(1));
    nRST = 1'b0;
    modelReset();
    #1;
    cmp("t6_rst_gv", 64'(grant_valid), 64'(0));
    cmp("t6_rst_wen", 64'(ramWEN), 64'(0));
    cmp("t6_rst_dwait", 64'(dwait), 64'(2'b11));
    cmp("t6_rst_addr", 64'(ramaddr), 64'(0));
    runCycle("t6");
    applyStimulus(2'b00, 2'b00, 2'b11, RS_ACCESS);
    nRST = 1'b1;
    runCycle("t6");
    applyStimulus(2'b00, 2'b00, 2'b11, RS_ACCESS);
    runCycle("t6");
    cmp("t6_regrant_gv", 64'(obs_gv), 64'(1));
    cmp("t6_regrant_owner", 64'(obs_owner), 64'(0));
    applyStimulus(2'b00, 2'b00, 2'b00, RS_ACCESS);
    runCycle("t6");
    runCycle("t6");

    // randomized traffic: requests mostly held, RAM state weighted toward ACCESS
    applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), RS_ACCESS);
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        0:       rs = RS_FREE;
        1:       rs = RS_BUSY;
        2:       rs = RS_ERROR;
        default: rs = RS_ACCESS;
      endcase
      if ($urandom_range(0, 5) == 0)
        applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), rs);
      else
        applyStimulus(iREN, dREN, dWEN, rs);
      runCycle("rand");
      if (n % 50 == 49) begin
        cmp("rand_rr_ptr", 64'(dut.rr_ptr_q), 64'(m_rr));
        cmp("rand_starve_cnt", 64'(dut.starve_cnt_q), 64'(m_starve));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
